// File: rtl/zmod_adc_cond_pkg.sv
// zmod_adc_cond_pkg: shared types, sample limits and saturation for the ADC sample conditioner
package zmod_adc_cond_pkg;
    typedef enum logic {S_IDLE, S_ACCUM} state_t;
    localparam int C_SAMPLE_W = 14;
    localparam int C_SAMPLE_MAX = 8191;
    localparam int C_SAMPLE_MIN = -8192;
    function automatic logic signed [C_SAMPLE_W-1:0] sat14(input logic signed [31:0] v);
        return v > C_SAMPLE_MAX ? 14'sd8191 : v < C_SAMPLE_MIN ? -14'sd8192 : v[C_SAMPLE_W-1:0];
    endfunction
endpackage

// File: rtl/zmod_adc_cond_channel.sv
// zmod_adc_cond_channel: offset (and optional gain) correction plus boxcar accumulator for one channel
// With ZMOD_ADC_COND_GAIN_EN the correction takes a second register stage for the Q2.14 multiply.
module zmod_adc_cond_channel
    import zmod_adc_cond_pkg::*;
#(
    parameter int P_ACC_W = 22
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [C_SAMPLE_W-1:0] data,
    input  logic [C_SAMPLE_W-1:0] offset,
`ifdef ZMOD_ADC_COND_GAIN_EN
    input  logic [15:0]           gain,
`endif
    input  logic                  acc_clr,
    input  logic                  acc_en,
    input  logic                  load,
    input  logic [3:0]            lat,
    output logic [C_SAMPLE_W-1:0] out
);
    logic signed [C_SAMPLE_W-1:0] s1, samp;
    logic signed [P_ACC_W-1:0] acc, acc_next;
    logic signed [P_ACC_W:0] rnd, sum;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) s1 <= '0;
        else s1 <= sat14(32'($signed(data)) + 32'($signed(offset)));
`ifdef ZMOD_ADC_COND_GAIN_EN
    logic signed [C_SAMPLE_W-1:0] s2;
    logic signed [31:0] prod;
    assign prod = 32'(s1) * $signed({16'd0, gain});
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) s2 <= '0;
        else s2 <= sat14((prod + 32'sd8192) >>> 14);
    assign samp = s2;
`else
    assign samp = s1;
`endif
    assign acc_next = acc + P_ACC_W'(samp);
    // Round half-up before the arithmetic shift; a window of one sample needs no rounding.
    assign rnd = (lat == 4'd0) ? '0 : (P_ACC_W+1)'(1) << (lat - 4'd1);
    assign sum = (P_ACC_W+1)'(acc_next) + rnd;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            acc <= '0;
            out <= '0;
        end else begin
            if (acc_clr || load) acc <= '0;
            else if (acc_en) acc <= acc_next;
            if (load) out <= C_SAMPLE_W'(sum >>> lat);
        end
endmodule

// File: rtl/zmod_adc_sample_conditioner.sv
// zmod_adc_sample_conditioner: offset-correct, boxcar-average and decimate ZMOD ADC channel pairs
// Define ZMOD_ADC_COND_GAIN_EN to add per-channel Q2.14 gain ports (one extra cycle of latency).
module zmod_adc_sample_conditioner
    import zmod_adc_cond_pkg::*;
#(
    parameter int P_DEC_LOG2_MAX = 8,
    parameter int P_ACC_W = C_SAMPLE_W + P_DEC_LOG2_MAX
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_adc_configured,
    input  logic                  i_data_valid,
    input  logic [C_SAMPLE_W-1:0] i14_data_a,
    input  logic [C_SAMPLE_W-1:0] i14_data_b,
    input  logic [C_SAMPLE_W-1:0] i14_offset_a,
    input  logic [C_SAMPLE_W-1:0] i14_offset_b,
    input  logic [3:0]            i4_dec_log2,
`ifdef ZMOD_ADC_COND_GAIN_EN
    input  logic [15:0]           i16_gain_a,
    input  logic [15:0]           i16_gain_b,
`endif
    output logic [C_SAMPLE_W-1:0] o14_data_a,
    output logic [C_SAMPLE_W-1:0] o14_data_b,
    output logic                  o_data_valid,
    output logic                  o_window_busy
);
    localparam int CW = P_DEC_LOG2_MAX + 1;
    state_t state;
    logic [CW-1:0] cnt, n_m1;
    logic [3:0] lat, dec_clamped;
    logic s1_valid, acc_valid, acc_en, acc_clr, last, load;
    assign dec_clamped = (32'(i4_dec_log2) > P_DEC_LOG2_MAX) ? 4'(P_DEC_LOG2_MAX) : i4_dec_log2;
    assign n_m1 = (CW'(1) << lat) - CW'(1);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) s1_valid <= 1'b0;
        else s1_valid <= i_data_valid;
`ifdef ZMOD_ADC_COND_GAIN_EN
    logic s2_valid;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) s2_valid <= 1'b0;
        else s2_valid <= s1_valid;
    assign acc_valid = s2_valid;
`else
    assign acc_valid = s1_valid;
`endif
    // Samples reaching the accumulator outside S_ACCUM, or while the ADC drops out, are discarded.
    assign acc_en = (state == S_ACCUM) && i_adc_configured && acc_valid;
    assign acc_clr = !i_adc_configured || (state == S_IDLE);
    assign last = cnt == n_m1;
    assign load = acc_en && last;
    assign o_window_busy = (state == S_ACCUM) && (cnt != '0);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= S_IDLE;
            cnt <= '0;
            lat <= '0;
            o_data_valid <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            if (!i_adc_configured) begin
                state <= S_IDLE;
                cnt <= '0;
            end else if (state == S_IDLE) begin
                state <= S_ACCUM;
                cnt <= '0;
                lat <= dec_clamped;
            end else if (acc_en) begin
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) lat <= dec_clamped;
                o_data_valid <= last;
            end
        end
    zmod_adc_cond_channel #(.P_ACC_W(P_ACC_W)) u_chan_a (
        .clk(clk), .rstn(rstn), .data(i14_data_a), .offset(i14_offset_a),
`ifdef ZMOD_ADC_COND_GAIN_EN
        .gain(i16_gain_a),
`endif
        .acc_clr(acc_clr), .acc_en(acc_en), .load(load), .lat(lat), .out(o14_data_a)
    );
    zmod_adc_cond_channel #(.P_ACC_W(P_ACC_W)) u_chan_b (
        .clk(clk), .rstn(rstn), .data(i14_data_b), .offset(i14_offset_b),
`ifdef ZMOD_ADC_COND_GAIN_EN
        .gain(i16_gain_b),
`endif
        .acc_clr(acc_clr), .acc_en(acc_en), .load(load), .lat(lat), .out(o14_data_b)
    );
endmodule

// File: tb/tb_zmod_adc_sample_conditioner.sv
// tb_zmod_adc_sample_conditioner: scoreboard bench for the ADC sample conditioner
module tb_zmod_adc_sample_conditioner;
    typedef struct { int a; int b; int cyc; } exp_t;
`ifdef ZMOD_ADC_COND_GAIN_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int DMAX = 8;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic i_adc_configured = 1'b0;
    logic i_data_valid = 1'b0;
    logic [13:0] i14_data_a = '0, i14_data_b = '0, i14_offset_a = '0, i14_offset_b = '0;
    logic [3:0] i4_dec_log2 = '0;
    logic [13:0] o14_data_a, o14_data_b;
    logic o_data_valid, o_window_busy;
    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    int off_a = 0, off_b = 0;
    int m_lat = 0, m_cnt = 0, m_sa = 0, m_sb = 0;
    exp_t q[$];

    zmod_adc_sample_conditioner dut (
        .clk(clk), .rstn(rstn), .i_adc_configured(i_adc_configured), .i_data_valid(i_data_valid),
        .i14_data_a(i14_data_a), .i14_data_b(i14_data_b),
        .i14_offset_a(i14_offset_a), .i14_offset_b(i14_offset_b), .i4_dec_log2(i4_dec_log2),
`ifdef ZMOD_ADC_COND_GAIN_EN
        .i16_gain_a(16'd16384), .i16_gain_b(16'd16384),
`endif
        .o14_data_a(o14_data_a), .o14_data_b(o14_data_b),
        .o_data_valid(o_data_valid), .o_window_busy(o_window_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat_m(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    function automatic int clamp_m(input int l);
        return l > DMAX ? DMAX : l;
    endfunction

    function automatic int avg_m(input int s, input int l);
        if (l == 0) return s;
        return (s + (1 << (l - 1))) >>> l;
    endfunction

    // Advance one clock and reconcile any strobe against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (o_data_valid === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL strobe_unexpected cyc=%0d got a=%0d b=%0d, required no strobe",
                         cyc, $signed(o14_data_a), $signed(o14_data_b));
            end else begin
                e = q.pop_front();
                if ($signed(o14_data_a) !== e.a || $signed(o14_data_b) !== e.b || cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL strobe_value got a=%0d b=%0d cyc=%0d, required a=%0d b=%0d cyc=%0d",
                             $signed(o14_data_a), $signed(o14_data_b), cyc, e.a, e.b, e.cyc);
                end
            end
        end else if (q.size() != 0 && cyc >= q[0].cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_missing cyc=%0d got no strobe, required a=%0d b=%0d at cyc=%0d",
                     cyc, q[0].a, q[0].b, q[0].cyc);
            void'(q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        i_data_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic feed(input int a, input int b);
        exp_t e;
        i14_data_a = 14'(a);
        i14_data_b = 14'(b);
        i_data_valid = 1'b1;
        m_sa += sat_m(a + off_a);
        m_sb += sat_m(b + off_b);
        m_cnt++;
        if (m_cnt == (1 << m_lat)) begin
            e.a = avg_m(m_sa, m_lat);
            e.b = avg_m(m_sb, m_lat);
            e.cyc = cyc + LAT;
            q.push_back(e);
            m_sa = 0;
            m_sb = 0;
            m_cnt = 0;
            m_lat = clamp_m(int'(i4_dec_log2));
        end
        tick();
    endtask

    task automatic restart(input int l);
        i_data_valid = 1'b0;
        i_adc_configured = 1'b0;
        tick();
        i4_dec_log2 = 4'(l);
        i_adc_configured = 1'b1;
        m_lat = clamp_m(l);
        m_cnt = 0;
        m_sa = 0;
        m_sb = 0;
        tick();
    endtask

    task automatic set_offsets(input int a, input int b);
        off_a = a;
        off_b = b;
        i14_offset_a = 14'(a);
        i14_offset_b = 14'(b);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++;
        if (o_data_valid !== 1'b0 || o14_data_a !== 14'd0 || o14_data_b !== 14'd0 || o_window_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold got v=%b a=%0d b=%0d busy=%b, required all 0",
                     o_data_valid, o14_data_a, o14_data_b, o_window_busy);
        end
        rstn = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (o_data_valid !== 1'b0 || o14_data_a !== 14'd0 || o14_data_b !== 14'd0 || o_window_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release got v=%b a=%0d b=%0d busy=%b, required all 0",
                     o_data_valid, o14_data_a, o14_data_b, o_window_busy);
        end
    endtask

    task automatic test_bypass();
        restart(0);
        for (int i = 0; i < 8; i++) feed(100, -100);
        idle(LAT + 2);
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL bypass_drain got %0d pending, required 0", q.size()); q.delete(); end
        n_cmp++;
        if ($signed(o14_data_a) !== 100 || $signed(o14_data_b) !== -100) begin
            n_bad++;
            $display("FAIL bypass_hold got a=%0d b=%0d, required 100/-100", $signed(o14_data_a), $signed(o14_data_b));
        end
    endtask

    task automatic test_saturation();
        restart(0);
        set_offsets(500, -500);
        for (int i = 0; i < 3; i++) feed(8000, -8000);
        feed(-8192, 8191);
        idle(LAT + 2);
        set_offsets(0, 0);
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL sat_drain got %0d pending, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_decimate();
        restart(2);
        feed(1, -1);
        feed(2, -2);
        idle(LAT);
        n_cmp++;
        if (o_window_busy !== 1'b1) begin n_bad++; $display("FAIL dec_busy got %b, required 1", o_window_busy); end
        feed(3, -3);
        feed(4, -4);
        idle(LAT + 2);
        n_cmp++;
        if (o_window_busy !== 1'b0) begin n_bad++; $display("FAIL dec_idle_busy got %b, required 0", o_window_busy); end
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL dec_drain got %0d pending, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_neg_round();
        restart(1);
        feed(-3, 3);
        feed(-4, 4);
        idle(LAT + 2);
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL negrnd_drain got %0d pending, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_abort();
        restart(3);
        for (int i = 0; i < 5; i++) feed(9, -9);
        i_data_valid = 1'b0;
        i_adc_configured = 1'b0;
        tick();
        n_cmp++;
        if (o_window_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b, required 0", o_window_busy); end
        i_adc_configured = 1'b1;
        m_lat = clamp_m(int'(i4_dec_log2));
        m_cnt = 0;
        m_sa = 0;
        m_sb = 0;
        for (int i = 0; i < 8; i++) feed(50, -50);
        idle(LAT + 2);
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL abort_drain got %0d pending, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_exp_change();
        restart(2);
        feed(1, 10);
        feed(2, 20);
        i4_dec_log2 = 4'd0;
        for (int i = 3; i <= 7; i++) feed(i, 10 * i);
        idle(LAT + 2);
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL expchg_drain got %0d pending, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_clamp();
        restart(15);
        for (int i = 0; i < 256; i++) begin
            feed((i % 16) * 100 - 700, 3000 - (i % 5) * 1500);
            if (i == 200) begin
                n_cmp++;
                if (o_window_busy !== 1'b1) begin n_bad++; $display("FAIL clamp_busy got %b, required 1", o_window_busy); end
            end
        end
        idle(LAT + 2);
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL clamp_drain got %0d pending, required 0", q.size()); q.delete(); end
    endtask

    task automatic test_back_to_back();
        restart(1);
        for (int i = 0; i < 12; i++) feed(int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192);
        idle(LAT + 2);
        n_cmp++;
        if (q.size() != 0) begin n_bad++; $display("FAIL b2b_drain got %0d pending, required 0", q.size()); q.delete(); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_saturation();
        test_decimate();
        test_neg_round();
        test_abort();
        test_exp_change();
        test_clamp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/zmod_adc_sample_conditioner.md
Name: zmod_adc_sample_conditioner

Overview:
- Downstream of the ZMOD ADC driver. Consumes the two parallel 14-bit channel words (A and B) once the driver reports the ADC configured.
- Per channel: applies an offset correction with saturation, then boxcar-averages and decimates by a runtime power of two.
- Emits decimated samples with a single-cycle valid strobe toward the Goertzel filter stage.
- No backpressure; the downstream stage must accept every strobe.

Parameters:
- P_DEC_LOG2_MAX, 8: maximum decimation exponent. Window length N = 2^i4_dec_log2, up to 2^P_DEC_LOG2_MAX.
- P_ACC_W, 14+P_DEC_LOG2_MAX: accumulator width per channel. Derived; never overridden.

Ports:
- clk  in  1  system clock; also the sample clock.
- rstn  in  1  reset, asynchronous, active-low.
- i_adc_configured  in  1  ADC configuration complete, from the driver.
- i_data_valid  in  1  a new sample pair is present this cycle.
- i14_data_a  in  14  channel A sample, signed two's complement.
- i14_data_b  in  14  channel B sample, signed two's complement.
- i14_offset_a  in  14  signed offset added to channel A.
- i14_offset_b  in  14  signed offset added to channel B.
- i4_dec_log2  in  4  decimation exponent. Values above P_DEC_LOG2_MAX clamp to P_DEC_LOG2_MAX.
- o14_data_a  out  14  decimated channel A, signed.
- o14_data_b  out  14  decimated channel B, signed.
- o_data_valid  out  1  one-cycle strobe per decimated pair.
- o_window_busy  out  1  a window is partially accumulated.

Behaviour:
- Reset (async assert, sync release inside the block): all registers 0. o14_data_a/b = 0, o_data_valid = 0, o_window_busy = 0, FSM = S_IDLE.
- Stage 1, registered 1 cycle after i_data_valid:
  - corrected = sat14(data + offset), computed at 15 bits.
  - Saturation limits are +8191 / -8192.
  - A stage-1 valid bit follows i_data_valid.
- Stage 2, the FSM:
  - S_IDLE:
    - Waits for i_adc_configured = 1.
    - Latches the clamped i4_dec_log2 into the window exponent.
    - Clears accumulators and the sample counter, then goes to S_ACCUM.
  - S_ACCUM:
    - On each stage-1 valid: acc += sign-extended corrected sample, count++.
    - On the sample that makes count == N: load the output registers and pulse o_data_valid for one cycle.
    - On that same cycle, clear acc, reset count to 0, and re-latch the exponent, so the next window starts with no gap cycle.
- Output arithmetic: out = (acc_total + 2^(L-1)) >>> L, arithmetic shift, where L is the latched exponent.
  - When L = 0 there is no rounding term.
  - The result always fits in 14 bits, so no output saturation is needed.
- Latency: o_data_valid rises 2 clk after the cycle in which the window's last i_data_valid sample is presented.
- L = 0 (bypass): every input sample yields a strobe 2 clk later. Continuous input gives continuous o_data_valid.
- i4_dec_log2 changes mid-window: ignored until the next window boundary.
- i_adc_configured drops at any time:
  - Partial window discarded; acc and count cleared.
  - Go to S_IDLE.
  - No strobe is emitted, including for a sample in flight in stage 1.
- o_window_busy = 1 in S_ACCUM while count != 0.
- o14_data_a/b hold their value between strobes.
- i_data_valid while in S_IDLE: dropped.
- Channels A and B always share one counter, so their windows are always aligned.

Optional Feature:
- Macro: ZMOD_ADC_COND_GAIN_EN.
- Defined:
  - Adds ports i16_gain_a and i16_gain_b, unsigned Q2.14 (16384 = 1.0).
  - Stage 1 becomes 2 cycles: offset-sat, then multiply by gain, round half-up at bit 14, sat14.
  - Total latency becomes 3 clk.
- Undefined: no gain ports; gain = 1.0 implied; latency 2 clk.

Decomposition:
- Package zmod_adc_cond_pkg holds:
  - state enum (S_IDLE, S_ACCUM);
  - constants C_SAMPLE_W = 14 and C_SAMPLE_MAX / C_SAMPLE_MIN;
  - function sat14.
- One sub-module: zmod_adc_cond_channel (offset/gain/accumulate datapath for one channel), instantiated twice.
- FSM and counter stay in the top module and are shared by both channels.

Test Plan:
- Bypass: L=0, offsets 0, A = 100 / B = -100 every cycle -> o_data_valid continuous from cycle 2, outputs 100 / -100.
- Saturation: A = 8000, offset_a = 500; B = -8000, offset_b = -500 -> outputs 8191 / -8192.
- Decimate: L=2, A = 1,2,3,4 -> single strobe, value 3 ((10+2)>>2); strobe 2 clk after the 4th sample.
- Negative rounding: L=1, A = -3,-4 -> -3 ((-7+1)>>>1).
- Mid-window abort: L=3, 5 samples, then i_adc_configured = 0 for 1 cycle, then 8 samples of 50 -> exactly one strobe, value 50.
- Exponent change mid-window: L=2 latched, i4_dec_log2 set to 0 after sample 2 -> first strobe after sample 4, then per-sample strobes; i4_dec_log2 = 15 with default params clamps to N = 256.
